// File: rtl/sdram_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_wb_arbiter
// Purpose  : Two-master round-robin arbiter in front of the pipelined Wishbone
//            SDRAM access port. Tracks accepted-but-unacked strobes so the
//            bus changes hands only once every issued access has been acked,
//            and bounds each tenure to BURST_MAX accepted strobes when the
//            other master is waiting.
// Ports    : clk, reset (async, active-low)
//            m0_* / m1_*  : Wishbone pipelined slave ports facing the masters
//            s_*          : Wishbone pipelined master port facing sdram_top
// Revision : 1.0  initial release
// ============================================================================
module sdram_wb_arbiter #(
  parameter int AW              = 32,
  parameter int DW              = 16,
  parameter int MAX_OUTSTANDING = 8,
  parameter int BURST_MAX       = 32
) (
  input  logic          clk,
  input  logic          reset,

  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_writedata,
  output logic [DW-1:0] m0_readdata,
  input  logic          m0_strobe,
  input  logic          m0_cycle,
  input  logic          m0_write,
  output logic          m0_ack,
  output logic          m0_stall,

  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_writedata,
  output logic [DW-1:0] m1_readdata,
  input  logic          m1_strobe,
  input  logic          m1_cycle,
  input  logic          m1_write,
  output logic          m1_ack,
  output logic          m1_stall,

  output logic [AW-1:0] s_address,
  output logic [DW-1:0] s_writedata,
  output logic          s_strobe,
  output logic          s_cycle,
  output logic          s_write,
  input  logic [DW-1:0] s_readdata,
  input  logic          s_ack,
  input  logic          s_stall
);

  localparam logic [7:0]  c_MAX_OUT   = 8'(MAX_OUTSTANDING);
  localparam logic [15:0] c_BURST_MAX = 16'(BURST_MAX);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_owner;
  logic        r_last;
  logic [7:0]  r_outst;
  logic [15:0] r_burst;

  logic        w_grant;
  logic        w_drain;
  logic        w_own_cyc;
  logic        w_own_stb;
  logic        w_oth_cyc;
  logic        w_burst_hit;
  logic        w_block;
  logic        w_accept;
  logic        w_ack_ok;
  logic        w_fwd_ack;
  logic        w_own_stall;
  logic [7:0]  w_outst_nxt;

  always_comb begin
    w_grant     = (r_state == ST_GRANT);
    w_drain     = (r_state == ST_DRAIN);
    w_own_cyc   = r_owner ? m1_cycle  : m0_cycle;
    w_own_stb   = r_owner ? m1_strobe : m0_strobe;
    w_oth_cyc   = r_owner ? m0_cycle  : m1_cycle;

    // Burst limit only bites while the other master is actually waiting.
    w_burst_hit = (r_burst == c_BURST_MAX) && w_oth_cyc;
    w_block     = (r_outst == c_MAX_OUT) || w_burst_hit;

    s_strobe    = w_grant && w_own_cyc && w_own_stb && !w_block;
    w_accept    = s_strobe && !s_stall;

    // An ack with nothing outstanding is a slave protocol error: drop it so
    // the counter cannot wrap and no master sees a phantom ack.
    w_ack_ok    = (w_grant || w_drain) && s_ack && (r_outst != 8'd0);
    w_fwd_ack   = w_ack_ok && w_own_cyc;

    case ({w_accept, w_ack_ok})
      2'b10:   w_outst_nxt = r_outst + 8'd1;
      2'b01:   w_outst_nxt = r_outst - 8'd1;
      default: w_outst_nxt = r_outst;
    endcase

    w_own_stall = !(w_grant && !(s_stall || w_block));

    s_cycle     = w_grant || w_drain;
    s_address   = '0;
    s_writedata = '0;
    s_write     = 1'b0;
    if (w_grant) begin
      s_address   = r_owner ? m1_address   : m0_address;
      s_writedata = r_owner ? m1_writedata : m0_writedata;
      s_write     = r_owner ? m1_write     : m0_write;
    end

    m0_stall    = r_owner ? 1'b1 : w_own_stall;
    m1_stall    = r_owner ? w_own_stall : 1'b1;
    m0_ack      = w_fwd_ack && !r_owner;
    m1_ack      = w_fwd_ack &&  r_owner;
    m0_readdata = s_readdata;
    m1_readdata = s_readdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_outst <= 8'd0;
      r_burst <= 16'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m0_cycle || m1_cycle) begin
            // On a tie the master that was not served last wins.
            r_owner <= (m0_cycle && m1_cycle) ? ~r_last : m1_cycle;
            r_burst <= 16'd0;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          r_outst <= w_outst_nxt;
          // Saturate at the limit so a long solo tenure still blocks as
          // soon as the other master shows up.
          if (w_accept && (r_burst != c_BURST_MAX)) begin
            r_burst <= r_burst + 16'd1;
          end
          if (!w_own_cyc || w_burst_hit) begin
            if (w_outst_nxt == 8'd0) begin
              r_state <= ST_IDLE;
              r_last  <= r_owner;
            end else begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_outst <= w_outst_nxt;
          if (w_outst_nxt == 8'd0) begin
            r_state <= ST_IDLE;
            r_last  <= r_owner;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
